xalu_seq: RTL and testbench

- Parametrised, sequential successor to the 4-bit combinational ALU slice.
- WIDTH-bit datapath with a valid/ready operand interface and valid/ready result interface.
- Single-cycle logic/arithmetic ops; multi-cycle shifts by a variable amount and shift-add multiply.
- Registered result doubles as accumulator; complement output mode; zero/neg-zero/equal status.

---
 rtl/xalu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_xalu_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xalu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : xalu_seq
//  Description : Sequential WIDTH-bit ALU with valid/ready operand and result
//                handshakes. Single-cycle logic/arithmetic operations,
//                multi-cycle variable shifts and a shift-add multiplier.
//                The result register doubles as the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module xalu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             com,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             co,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SHL = 3'd5;
    localparam logic [2:0] c_OP_SHR = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    localparam logic [SHW:0] c_MUL_STEPS = (SHW+1)'(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [2:0]       r_op;
    logic             r_ci;
    logic             r_com;
    logic             r_equ;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [SHW:0]     r_cnt;

    logic [WIDTH-1:0]   w_a_eff;
    logic [SHW:0]       w_amt;
    logic               w_single;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_r1;
    logic               w_co1;
    logic [WIDTH-1:0]   w_y1;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_lo_nx;
    logic [WIDTH-1:0]   w_hi_nx;
    logic               w_co_step;
    logic [WIDTH-1:0]   w_y_step;
    logic               w_last;

    assign w_a_eff   = use_acc ? y : a;
    assign w_amt     = {1'b0, b[SHW-1:0]};
    // Shifts by zero complete in the accept cycle like the logic ops.
    assign w_single  = (op != c_OP_MUL) &&
                       !(((op == c_OP_SHL) || (op == c_OP_SHR)) && (w_amt != '0));
    assign w_last    = (r_cnt == (SHW+1)'(1));
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);

    // Single-cycle result from the live operands; a zero-amount shift passes A.
    always_comb begin
        w_sum = '0;
        w_r1  = w_a_eff;
        w_co1 = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_sum = {1'b0, w_a_eff} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                w_r1  = w_sum[WIDTH-1:0];
                w_co1 = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_sum = {1'b0, w_a_eff} + {1'b0, ~b} + {{WIDTH{1'b0}}, ci};
                w_r1  = w_sum[WIDTH-1:0];
                w_co1 = w_sum[WIDTH];
            end
            c_OP_AND: w_r1 = w_a_eff & b;
            c_OP_OR:  w_r1 = w_a_eff | b;
            c_OP_XOR: w_r1 = w_a_eff ^ b;
            default:  w_r1 = w_a_eff;
        endcase
        w_y1 = w_r1 ^ {WIDTH{com}};
    end

    // One iteration of the multi-cycle shift or shift-add multiply.
    always_comb begin
        w_lo_nx   = r_lo;
        w_hi_nx   = '0;
        w_co_step = 1'b0;
        w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_prod    = {w_madd, r_lo[WIDTH-1:1]};
        case (r_op)
            c_OP_SHL: begin
                w_lo_nx   = {r_lo[WIDTH-2:0], r_ci};
                w_co_step = r_lo[WIDTH-1];
            end
            c_OP_SHR: begin
                w_lo_nx   = {r_ci, r_lo[WIDTH-1:1]};
                w_co_step = r_lo[0];
            end
            default: begin
                w_hi_nx = w_prod[2*WIDTH-1:WIDTH];
                w_lo_nx = w_prod[WIDTH-1:0];
            end
        endcase
        w_y_step = w_lo_nx ^ {WIDTH{r_com}};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state selection.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_nx = w_single ? c_DONE : c_BUSY;
            c_BUSY:  if (w_last) w_state_nx = c_DONE;
            c_DONE:  if (out_ready) w_state_nx = c_IDLE;
            default: w_state_nx = c_IDLE;
        endcase
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_ci     <= 1'b0;
            r_com    <= 1'b0;
            r_equ    <= 1'b0;
            r_a      <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_cnt    <= '0;
            y        <= '0;
            y_hi     <= '0;
            co       <= 1'b0;
            zero     <= 1'b0;
            neg_zero <= 1'b0;
            equ      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_ci  <= ci;
                        r_com <= com;
                        r_a   <= w_a_eff;
                        r_equ <= (w_a_eff == b);
                        if (w_single) begin
                            y        <= w_y1;
                            y_hi     <= '0;
                            co       <= w_co1;
                            zero     <= (w_y1 == '0);
                            neg_zero <= (w_y1 == '1);
                            equ      <= (w_a_eff == b);
                        end else if (op == c_OP_MUL) begin
                            r_lo  <= b;
                            r_hi  <= '0;
                            r_cnt <= c_MUL_STEPS;
                        end else begin
                            r_lo  <= w_a_eff;
                            r_hi  <= '0;
                            r_cnt <= w_amt;
                        end
                    end
                end
                c_BUSY: begin
                    r_lo  <= w_lo_nx;
                    r_hi  <= w_hi_nx;
                    r_cnt <= r_cnt - (SHW+1)'(1);
                    if (w_last) begin
                        y        <= w_y_step;
                        y_hi     <= w_hi_nx;
                        co       <= w_co_step;
                        zero     <= (w_y_step == '0);
                        neg_zero <= (w_y_step == '1);
                        equ      <= r_equ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xalu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xalu_seq
//  Description : Directed self-checking bench for xalu_seq (WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_xalu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       com;
    logic       use_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] y_hi;
    logic       co;
    logic       zero;
    logic       neg_zero;
    logic       equ;

    int n_chk  = 0;
    int n_fail = 0;

    xalu_seq #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .com       (com),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .co        (co),
        .zero      (zero),
        .neg_zero  (neg_zero),
        .equ       (equ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for out_valid, check latency and results.
    task automatic run(input string tag, input logic [2:0] t_op, input logic [7:0] t_a,
                       input logic [7:0] t_b, input logic t_ci, input logic t_com,
                       input logic t_acc, input int exp_lat, input logic [7:0] exp_y,
                       input logic [7:0] exp_hi, input logic exp_co);
        int lat;
        logic saw_ready;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; ci = t_ci; com = t_com; use_acc = t_acc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_acc  = 1'b0;
        lat = 1;
        saw_ready = in_ready;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            saw_ready = saw_ready | in_ready;
        end
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " in_ready"}, saw_ready, 1'b0);
        check({tag, " y"}, y, exp_y);
        check({tag, " y_hi"}, y_hi, exp_hi);
        check({tag, " co"}, co, exp_co);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        ci = 1'b0; com = 1'b0; use_acc = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst y", y, 8'h00);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst flags", {co, zero, neg_zero, equ}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        run("add", 3'd0, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b0, 1, 8'h11, 8'h00, 1'b1);
        check("add zero", zero, 1'b0);
        check("add equ", equ, 1'b0);
        consume();

        run("sub", 3'd1, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 1, 8'h00, 8'h00, 1'b1);
        check("sub zero", zero, 1'b1);
        check("sub equ", equ, 1'b1);
        consume();

        run("subc", 3'd1, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 1, 8'hFF, 8'h00, 1'b1);
        check("subc neg_zero", neg_zero, 1'b1);
        check("subc zero", zero, 1'b0);
        consume();

        run("shl3", 3'd5, 8'h81, 8'h03, 1'b0, 1'b0, 1'b0, 4, 8'h08, 8'h00, 1'b0);
        consume();

        run("shr1", 3'd6, 8'h81, 8'h01, 1'b1, 1'b0, 1'b0, 2, 8'hC0, 8'h00, 1'b1);
        consume();

        // Upper bits of b ignored for shift amount: 0x09 -> amount 1.
        run("shl_hi", 3'd5, 8'h40, 8'h09, 1'b0, 1'b0, 1'b0, 2, 8'h80, 8'h00, 1'b0);
        consume();

        // Amount 0 (b=0x08 -> low bits 0) passes A in one cycle.
        run("shr0", 3'd6, 8'h5A, 8'h08, 1'b1, 1'b0, 1'b0, 1, 8'h5A, 8'h00, 1'b0);
        consume();

        run("and", 3'd2, 8'hCC, 8'hAA, 1'b1, 1'b0, 1'b0, 1, 8'h88, 8'h00, 1'b0);
        consume();
        run("xor", 3'd4, 8'hCC, 8'hAA, 1'b0, 1'b0, 1'b0, 1, 8'h66, 8'h00, 1'b0);
        consume();

        run("mul", 3'd7, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 9, 8'h01, 8'hFE, 1'b0);
        consume();
        run("mul0", 3'd7, 8'h00, 8'h37, 1'b0, 1'b0, 1'b0, 9, 8'h00, 8'h00, 1'b0);
        check("mul0 zero", zero, 1'b1);
        consume();
        run("mul2", 3'd7, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 9, 8'ha8, 8'h03, 1'b0);
        consume();

        // Back-pressure: result held while out_ready stays low.
        run("add7", 3'd0, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1, 8'h07, 8'h00, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold y", y, 8'h07);
            check("hold out_valid", out_valid, 1'b1);
            check("hold in_ready", in_ready, 1'b0);
        end
        consume();
        check("release out_valid", out_valid, 1'b0);
        check("release in_ready", in_ready, 1'b1);
        run("acc", 3'd0, 8'h55, 8'h01, 1'b0, 1'b0, 1'b1, 1, 8'h08, 8'h00, 1'b0);
        consume();

        // Reset during the fourth BUSY cycle of a multiply.
        @(negedge clk);
        op = 3'd7; a = 8'h12; b = 8'h34; ci = 1'b0; com = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort y", y, 8'h00);
        check("abort y_hi", y_hi, 8'h00);
        check("abort out_valid", out_valid, 1'b0);
        check("abort in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run("post", 3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1, 8'h02, 8'h00, 1'b0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
